// File: rtl/usr_pkg.sv
// Shared definitions for the universal burst shift register: mode codes, FSM states.
// Optional feature macro: USR_ROTATE_EN (enables ROL/ROR, including rotate bursts).
package usr_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD  = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHL   = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHR   = 3'b010;
  localparam logic [MODE_W-1:0] MODE_LOAD  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROL   = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROR   = 3'b101;
  localparam logic [MODE_W-1:0] MODE_CLR   = 3'b110;
  localparam logic [MODE_W-1:0] MODE_HOLD2 = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Modes that may run as a multi-step burst; rotates only when built in.
  function automatic logic is_burst_op(input logic [MODE_W-1:0] m);
    logic r;
    r = (m == MODE_SHL) || (m == MODE_SHR);
`ifdef USR_ROTATE_EN
    r = r || (m == MODE_ROL) || (m == MODE_ROR);
`endif
    return r;
  endfunction

endpackage

// File: rtl/usr_shift_core.sv
// WIDTH-bit storage register with its next-value mux; updates only on upd_i.
// Optional feature macro: USR_ROTATE_EN (without it, rotate codes hold).
module usr_shift_core
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_i,
  input  logic [MODE_W-1:0] op_i,
  input  logic [WIDTH-1:0]  pdata_i,
  input  logic              sin_lsb_i,
  input  logic              sin_msb_i,
  output logic [WIDTH-1:0]  q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (upd_i) begin
      case (op_i)
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin_lsb_i};
        MODE_SHR:  q_d = {sin_msb_i, q_q[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
        MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
`endif
        MODE_LOAD: q_d = pdata_i;
        MODE_CLR:  q_d = '0;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/usr_burst_shifter.sv
// Universal shift register with an autonomous N-step shift/rotate burst sequencer.
// Optional feature macro: USR_ROTATE_EN (rotate modes and rotate bursts).
module usr_burst_shifter
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  pdata_in,
  input  logic              sin_lsb,
  input  logic              sin_msb,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  output logic [WIDTH-1:0]  q,
  output logic              sout_msb,
  output logic              sout_lsb,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [MODE_W-1:0] op_q, op_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              core_upd;
  logic [MODE_W-1:0] core_op;

  // Handshake: start is sampled only in IDLE with en high; the first burst step
  // happens on the accepting edge, done is a one-cycle pulse after the last step.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    op_d     = op_q;
    done_d   = 1'b0;
    core_upd = 1'b0;
    core_op  = mode;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          if (start && is_burst_op(mode)) begin
            if (count == '0) begin
              done_d = 1'b1;
            end else begin
              core_upd = 1'b1;
              op_d     = mode;
              rem_d    = count - 1'b1;
              if (count == CNT_W'(1)) done_d  = 1'b1;
              else                    state_d = ST_BURST;
            end
          end else begin
            core_upd = 1'b1;
          end
        end
      end
      ST_BURST: begin
        core_op = op_q;
        if (en) begin
          core_upd = 1'b1;
          rem_d    = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_BURST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      op_q    <= MODE_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  usr_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .upd_i     (core_upd),
    .op_i      (core_op),
    .pdata_i   (pdata_in),
    .sin_lsb_i (sin_lsb),
    .sin_msb_i (sin_msb),
    .q_o       (q)
  );

  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_usr_burst_shifter.sv
// Directed bench for usr_burst_shifter with hand-computed expectations.
// Honours USR_ROTATE_EN the same way the design does.
module tb_usr_burst_shifter;
  import usr_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [MODE_W-1:0] mode;
  logic [WIDTH-1:0]  pdata_in;
  logic              sin_lsb;
  logic              sin_msb;
  logic              start;
  logic [CNT_W-1:0]  count;
  logic [WIDTH-1:0]  q;
  logic              sout_msb;
  logic              sout_lsb;
  logic              busy;
  logic              done;

  int tests_run = 0;
  int tests_failed = 0;
  logic [WIDTH-1:0] exp_q[$];

  usr_burst_shifter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .pdata_in (pdata_in),
    .sin_lsb  (sin_lsb),
    .sin_msb  (sin_msb),
    .start    (start),
    .count    (count),
    .q        (q),
    .sout_msb (sout_msb),
    .sout_lsb (sout_lsb),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [MODE_W-1:0] m, input logic s, input logic [CNT_W-1:0] c);
    mode  = m;
    start = s;
    count = c;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    drive(MODE_LOAD, 1'b0, '0);
    pdata_in = v;
    tick();
  endtask

  task automatic check_status(input string tag, input logic exp_busy, input logic exp_done);
    check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    check({tag, "_done"}, 32'(done), 32'(exp_done));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = MODE_LOAD; pdata_in = 8'hFF;
    sin_lsb = 1'b0; sin_msb = 1'b0; start = 1'b0; count = '0;
    tick();
    tick();
    check("rst_q", 32'(q), 32'h00);
    check_status("rst", 1'b0, 1'b0);
    check("rst_sout", 32'({sout_msb, sout_lsb}), 32'h0);
    rst = 1'b0;

    // Single steps
    load(8'hA5);
    check("load_q", 32'(q), 32'hA5);
    check("load_sout", 32'({sout_msb, sout_lsb}), 32'h3);
    drive(MODE_SHL, 1'b0, '0); sin_lsb = 1'b1; tick();
    check("shl_q", 32'(q), 32'h4B);
    drive(MODE_SHR, 1'b0, '0); sin_msb = 1'b0; tick();
    check("shr_q", 32'(q), 32'h25);
    drive(MODE_HOLD, 1'b0, '0); tick();
    check("hold_q", 32'(q), 32'h25);
    drive(MODE_HOLD2, 1'b0, '0); tick();
    check("hold2_q", 32'(q), 32'h25);
    en = 1'b0; drive(MODE_LOAD, 1'b0, '0); pdata_in = 8'h3C; tick();
    check("en_low_q", 32'(q), 32'h25);
    en = 1'b1; drive(MODE_CLR, 1'b0, '0); tick();
    check("clr_q", 32'(q), 32'h00);

    // Rotates
    load(8'h81);
    drive(MODE_ROL, 1'b0, '0); tick();
`ifdef USR_ROTATE_EN
    check("rol_q", 32'(q), 32'h03);
    drive(MODE_ROR, 1'b0, '0); tick();
    check("ror_q", 32'(q), 32'h81);
    drive(MODE_ROL, 1'b1, 4'd2); tick();
    check("rolb1_q", 32'(q), 32'h03);
    check_status("rolb1", 1'b1, 1'b0);
    drive(MODE_HOLD, 1'b0, '0); tick();
    check("rolb2_q", 32'(q), 32'h06);
    check_status("rolb2", 1'b0, 1'b1);
`else
    check("rol_q", 32'(q), 32'h81);
    drive(MODE_ROR, 1'b0, '0); tick();
    check("ror_q", 32'(q), 32'h81);
    drive(MODE_ROL, 1'b1, 4'd2); tick();
    check("rolb1_q", 32'(q), 32'h81);
    check_status("rolb1", 1'b0, 1'b0);
    drive(MODE_HOLD, 1'b0, '0); tick();
    check_status("rolb2", 1'b0, 1'b0);
`endif

    // Burst of 3 SHL, inputs other than en ignored after acceptance
    load(8'h01);
    exp_q.push_back(8'h02); exp_q.push_back(8'h04); exp_q.push_back(8'h08);
    sin_lsb = 1'b0;
    drive(MODE_SHL, 1'b1, 4'd3); tick();
    check("b1_q", 32'(q), 32'(exp_q.pop_front()));
    check_status("b1", 1'b1, 1'b0);
    drive(MODE_LOAD, 1'b1, 4'd9); pdata_in = 8'hFF; tick();
    check("b2_q", 32'(q), 32'(exp_q.pop_front()));
    check_status("b2", 1'b1, 1'b0);
    drive(MODE_HOLD, 1'b0, '0); tick();
    check("b3_q", 32'(q), 32'(exp_q.pop_front()));
    check_status("b3", 1'b0, 1'b1);
    tick();
    check_status("b4", 1'b0, 1'b0);

    // Same burst with two stalled cycles
    load(8'h01);
    drive(MODE_SHL, 1'b1, 4'd3); tick();
    check("s1_q", 32'(q), 32'h02);
    drive(MODE_HOLD, 1'b0, '0);
    en = 1'b0; tick();
    check("s2_q", 32'(q), 32'h02);
    check_status("s2", 1'b1, 1'b0);
    tick();
    check_status("s3", 1'b1, 1'b0);
    en = 1'b1; tick();
    check("s4_q", 32'(q), 32'h04);
    check_status("s4", 1'b1, 1'b0);
    tick();
    check("s5_q", 32'(q), 32'h08);
    check_status("s5", 1'b0, 1'b1);

    // count=0, count=1, then back-to-back start while done is high
    drive(MODE_SHL, 1'b1, 4'd0); tick();
    check("c0_q", 32'(q), 32'h08);
    check_status("c0", 1'b0, 1'b1);
    sin_lsb = 1'b1;
    drive(MODE_SHL, 1'b1, 4'd1); tick();
    check("c1_q", 32'(q), 32'h11);
    check_status("c1", 1'b0, 1'b1);
    sin_lsb = 1'b0;
    drive(MODE_SHL, 1'b1, 4'd2); tick();
    check("bb1_q", 32'(q), 32'h22);
    check_status("bb1", 1'b1, 1'b0);
    drive(MODE_HOLD, 1'b0, '0); tick();
    check("bb2_q", 32'(q), 32'h44);
    check_status("bb2", 1'b0, 1'b1);

    // Start dropped while disabled in IDLE
    en = 1'b0; drive(MODE_SHL, 1'b1, 4'd3); tick();
    en = 1'b1; drive(MODE_HOLD, 1'b0, '0); tick();
    check("drop_q", 32'(q), 32'h44);
    check_status("drop", 1'b0, 1'b0);

    // Serial input sampled live on each burst step
    load(8'h00);
    sin_lsb = 1'b1; drive(MODE_SHL, 1'b1, 4'd3); tick();
    check("live1_q", 32'(q), 32'h01);
    sin_lsb = 1'b0; drive(MODE_HOLD, 1'b0, '0); tick();
    check("live2_q", 32'(q), 32'h02);
    sin_lsb = 1'b1; tick();
    check("live3_q", 32'(q), 32'h05);
    check_status("live3", 1'b0, 1'b1);

    // Reset aborts a count=5 SHR burst
    load(8'h44);
    sin_msb = 1'b1; drive(MODE_SHR, 1'b1, 4'd5); tick();
    check("ra1_q", 32'(q), 32'hA2);
    drive(MODE_HOLD, 1'b0, '0); tick();
    check("ra2_q", 32'(q), 32'hD1);
    check_status("ra2", 1'b1, 1'b0);
    rst = 1'b1; tick();
    check("ra3_q", 32'(q), 32'h00);
    check_status("ra3", 1'b0, 1'b0);
    rst = 1'b0; tick();
    check("ra4_q", 32'(q), 32'h00);
    check_status("ra4", 1'b0, 1'b0);
    tick();
    check_status("ra5", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
